ysyx_23060025_icache: RTL and testbench
=======================================

Name: ysyx_23060025_icache

Overview:
Direct-mapped, read-only instruction cache. It is the responder side of the IFU fetch interface (psel/paddr request, pready/prdata response). Hits are served from on-chip arrays. Misses refill one full line from memory over an AXI4 read-only burst master port, then answer the IFU. It also supports whole-cache invalidation for fence.i.

Parameters:
ADDR_WIDTH, 32, physical address width
DATA_WIDTH, 32, instruction word / AXI data width
LINE_WORDS, 4, words per line (power of 2, ≥2); offset bits OB = log2(LINE_WORDS*4)
SETS, 16, number of lines (power of 2); index bits IB = log2(SETS); tag = ADDR_WIDTH-IB-OB bits

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
in_psel  in  1  IFU request; held high with in_paddr stable until in_pready
in_paddr  in  ADDR_WIDTH  fetch address; bits [1:0] ignored
in_pready  out  1  one-cycle response pulse; in_prdata valid only in this cycle
in_prdata  out  DATA_WIDTH  fetched instruction
fencei_i  in  1  one-cycle pulse: invalidate all lines
axi_araddr  out  ADDR_WIDTH  line-aligned refill address
axi_arvalid  out  1  AR valid
axi_arready  in  1  AR ready
axi_arlen  out  8  constant LINE_WORDS-1
axi_arsize  out  3  constant 3'b010
axi_arburst  out  2  constant 2'b01 (INCR)
axi_rdata  in  DATA_WIDTH  R data
axi_rresp  in  2  R response
axi_rlast  in  1  last beat
axi_rvalid  in  1  R valid
axi_rready  out  1  R ready

Behaviour:
- Reset: state IDLE; all valid bits 0; in_pready, axi_arvalid, axi_rready = 0; in_prdata = 0; beat counter 0; pending-invalidate flag 0. The data array is not reset.
- Address split: tag = paddr[ADDR_WIDTH-1:IB+OB], index = paddr[IB+OB-1:OB], word = paddr[OB-1:2].
- State machine:
  - IDLE: if in_psel, latch in_paddr into req_addr and go to LOOKUP.
  - LOOKUP: if valid[index] and tag matches, this is a hit. Drive in_pready=1 and in_prdata=data[index][word] for this cycle, then return to IDLE. Otherwise go to MISS_AR.
  - MISS_AR: axi_arvalid=1 with axi_araddr={tag,index,OB'b0}. Hold arvalid and araddr stable until axi_arready, then go to MISS_R.
  - MISS_R: axi_rready=1. Each rvalid beat writes data[index][beat_cnt] and increments beat_cnt. On a beat with rlast=1, go to RESP.
  - RESP: in_pready=1, in_prdata=data[index][word] (just-refilled line), beat_cnt cleared, then return to IDLE.
- Latency: hit is 1 cycle. in_psel sampled in cycle N gives in_pready in cycle N+1. Miss: in_pready one cycle after the rlast beat is accepted.
- in_pready is exactly one cycle per accepted request and never asserts in IDLE. A new request can be accepted in the cycle after in_pready.
- Line commit: on the rlast beat, set valid[index]=1 and tag[index]=tag, except in these cases:
  - any beat of this burst had rresp≠2'b00, or
  - fencei_i was seen during MISS_AR/MISS_R (pending-invalidate flag), or
  - fencei_i is high in the rlast cycle.
  In those cases valid[index] stays 0. The IFU still receives the refilled word in RESP.
- fencei_i outside refill: clears all valid bits at the next edge. If it coincides with a LOOKUP hit, that hit still returns data this cycle. Later lookups miss.
- rlast before LINE_WORDS beats, or extra beats: protocol violation, not supported. beat_cnt wraps modulo LINE_WORDS.
- in_psel dropping mid-request: not supported by the IFU contract. The cache still completes the transaction.
- Reset mid-refill: immediate return to IDLE with all valid bits 0. The memory side is reset by the same signal.

Test Plan:
- Cold miss: psel, paddr=0x8000_0008; AR must show araddr=0x8000_0000, arlen=3, arsize=2, arburst=1. R beats 0x11,0x22,0x33,0x44 (rlast on 4th) → one pready pulse the cycle after rlast, prdata=0x33; line 0 valid.
- Hit after fill: paddr=0x8000_000C → pready exactly 1 cycle after psel, prdata=0x44, no AR activity.
- Conflict eviction: paddr=0x8000_0100 (same index 0, new tag) → miss and refill; then 0x8000_0000 misses again.
- arready held low 5 cycles: arvalid and araddr stable throughout; rready stays 0 until the handshake.
- fence.i: pulse fencei_i after filling line 0 → a 0x8000_0000 request misses. Pulse fencei_i during MISS_R → data returned, but an immediate re-fetch of the same line misses again.
- rresp=2'b10 on beat 2 → pready still asserted with requested word; next access to the line misses. Reset during MISS_R → arvalid/rready/pready low next cycle, cache empty.

Source files
------------

// File: rtl/ysyx_23060025_icache_if.sv
// Bus bundles for the instruction cache: IFU fetch port and AXI4 read-only refill port.

interface ysyx_23060025_icache_ifu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  in_psel;
    logic [ADDR_WIDTH-1:0] in_paddr;
    logic                  in_pready;
    logic [DATA_WIDTH-1:0] in_prdata;

    // IFU side issues the request
    modport master (output in_psel, in_paddr, input in_pready, in_prdata);
    // cache side answers it
    modport slave  (input in_psel, in_paddr, output in_pready, in_prdata);
endinterface

interface ysyx_23060025_icache_axi_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] axi_araddr;
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic [7:0]            axi_arlen;
    logic [2:0]            axi_arsize;
    logic [1:0]            axi_arburst;
    logic [DATA_WIDTH-1:0] axi_rdata;
    logic [1:0]            axi_rresp;
    logic                  axi_rlast;
    logic                  axi_rvalid;
    logic                  axi_rready;

    // cache side issues refill bursts
    modport master (output axi_araddr, axi_arvalid, axi_arlen, axi_arsize, axi_arburst, axi_rready,
                    input  axi_arready, axi_rdata, axi_rresp, axi_rlast, axi_rvalid);
    // memory side serves them
    modport slave  (input  axi_araddr, axi_arvalid, axi_arlen, axi_arsize, axi_arburst, axi_rready,
                    output axi_arready, axi_rdata, axi_rresp, axi_rlast, axi_rvalid);
endinterface

// File: rtl/ysyx_23060025_icache.sv
// Direct-mapped read-only instruction cache with AXI4 burst line refill and fence.i flush.

module ysyx_23060025_icache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic fencei_i,
    ysyx_23060025_icache_ifu_if.slave  ifu,
    ysyx_23060025_icache_axi_if.master axi
);
    localparam int OB = $clog2(LINE_WORDS * 4);
    localparam int IB = $clog2(SETS);
    localparam int TW = ADDR_WIDTH - IB - OB;
    localparam int WB = OB - 2;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_MISS_AR = 3'd2;
    localparam logic [2:0] S_MISS_R  = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    logic [2:0]              state;
    logic [ADDR_WIDTH-1:2]   req_addr;   // byte offset within a word is irrelevant
    logic [SETS-1:0]         valid_q;
    logic [TW-1:0]           tag_q  [SETS];
    logic [DATA_WIDTH-1:0]   data_q [SETS][LINE_WORDS];
    logic [WB-1:0]           beat_cnt;
    logic                    pend_inv;   // fence.i seen while this refill was in flight
    logic                    resp_err;   // an earlier beat of this burst reported an error

    logic [TW-1:0] req_tag;
    logic [IB-1:0] req_idx;
    logic [WB-1:0] req_word;
    logic          hit;
    logic          bad_beat;
    logic          commit;

    assign req_tag  = req_addr[ADDR_WIDTH-1:IB+OB];
    assign req_idx  = req_addr[IB+OB-1:OB];
    assign req_word = req_addr[OB-1:2];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign bad_beat = (axi.axi_rresp != 2'b00);
    // the line only becomes valid if the whole burst was clean and no flush raced it
    assign commit   = (state == S_MISS_R) && axi.axi_rvalid && axi.axi_rlast &&
                      !(resp_err || bad_beat || pend_inv || fencei_i);

    // control FSM, valid bits and refill bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            req_addr <= '0;
            valid_q  <= '0;
            beat_cnt <= '0;
            pend_inv <= 1'b0;
            resp_err <= 1'b0;
        end else begin
            if (fencei_i) valid_q <= '0;
            if (commit) valid_q[req_idx] <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (ifu.in_psel) begin
                        req_addr <= ifu.in_paddr[ADDR_WIDTH-1:2];
                        state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: state <= hit ? S_IDLE : S_MISS_AR;
                S_MISS_AR: begin
                    if (fencei_i) pend_inv <= 1'b1;
                    if (axi.axi_arready) state <= S_MISS_R;
                end
                S_MISS_R: begin
                    if (fencei_i) pend_inv <= 1'b1;
                    if (axi.axi_rvalid) begin
                        beat_cnt <= beat_cnt + WB'(1);
                        if (bad_beat) resp_err <= 1'b1;
                        if (axi.axi_rlast) state <= S_RESP;
                    end
                end
                S_RESP: begin
                    beat_cnt <= '0;
                    pend_inv <= 1'b0;
                    resp_err <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // line storage: data captured per beat, tag only when the line commits; not reset
    always_ff @(posedge clock) begin
        if (state == S_MISS_R && axi.axi_rvalid) data_q[req_idx][beat_cnt] <= axi.axi_rdata;
        if (commit) tag_q[req_idx] <= req_tag;
    end

    // response to the IFU: hit in LOOKUP or the just-refilled word in RESP
    always_comb begin
        ifu.in_pready = 1'b0;
        ifu.in_prdata = '0;
        if ((state == S_LOOKUP && hit) || state == S_RESP) begin
            ifu.in_pready = 1'b1;
            ifu.in_prdata = data_q[req_idx][req_word];
        end
    end

    assign axi.axi_arvalid = (state == S_MISS_AR);
    assign axi.axi_araddr  = {req_addr[ADDR_WIDTH-1:OB], {OB{1'b0}}};
    assign axi.axi_arlen   = 8'(LINE_WORDS - 1);
    assign axi.axi_arsize  = 3'b010;
    assign axi.axi_arburst = 2'b01;
    assign axi.axi_rready  = (state == S_MISS_R);
endmodule

// File: tb/tb_ysyx_23060025_icache.sv
// Directed table-driven bench for the instruction cache.

module tb_ysyx_23060025_icache;
    logic clock = 1'b0;
    logic reset;
    logic fencei_i;

    ysyx_23060025_icache_ifu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifu ();
    ysyx_23060025_icache_axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    ysyx_23060025_icache #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(4), .SETS(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .fencei_i (fencei_i),
        .ifu      (ifu.slave),
        .axi      (axi.master)
    );

    always #5 clock = ~clock;

    // fence_at: -1 none, 0..3 during that R beat, 8 during the LOOKUP cycle
    typedef struct {
        logic [31:0]       addr;
        bit                miss;
        logic [31:0]       araddr;
        int                ar_wait;
        logic [3:0][31:0]  beats;
        int                err_beat;
        int                fence_at;
        bit                pre_fence;
        logic [31:0]       exp;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    vec_t vt [15];

    function automatic vec_t mk(input logic [31:0] addr, input bit miss, input logic [31:0] araddr,
                                input int ar_wait, input logic [127:0] beats, input int err_beat,
                                input int fence_at, input bit pre_fence, input logic [31:0] exp);
        vec_t v;
        v.addr = addr; v.miss = miss; v.araddr = araddr; v.ar_wait = ar_wait;
        v.beats = beats; v.err_beat = err_beat; v.fence_at = fence_at;
        v.pre_fence = pre_fence; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic run(input int k, input vec_t v);
        if (v.pre_fence) begin
            fencei_i = 1'b1;
            @(negedge clock);
            fencei_i = 1'b0;
        end
        ifu.in_psel  = 1'b1;
        ifu.in_paddr = v.addr;
        @(negedge clock);                       // LOOKUP
        if (!v.miss) begin
            chk($sformatf("v%0d.hit_pready", k), 32'(ifu.in_pready), 32'd1);
            chk($sformatf("v%0d.hit_data", k), ifu.in_prdata, v.exp);
            chk($sformatf("v%0d.hit_no_ar", k), 32'(axi.axi_arvalid), 32'd0);
            if (v.fence_at == 8) fencei_i = 1'b1;
            ifu.in_psel = 1'b0;
            @(negedge clock);
            fencei_i = 1'b0;
            chk($sformatf("v%0d.idle_pready", k), 32'(ifu.in_pready), 32'd0);
            return;
        end
        chk($sformatf("v%0d.lookup_pready", k), 32'(ifu.in_pready), 32'd0);
        @(negedge clock);                       // MISS_AR
        chk($sformatf("v%0d.arvalid", k), 32'(axi.axi_arvalid), 32'd1);
        chk($sformatf("v%0d.araddr", k), axi.axi_araddr, v.araddr);
        chk($sformatf("v%0d.arlen_size_burst", k),
            {19'd0, axi.axi_arlen, axi.axi_arsize, axi.axi_arburst}, {19'd0, 8'd3, 3'd2, 2'd1});
        chk($sformatf("v%0d.ar_rready", k), 32'(axi.axi_rready), 32'd0);
        for (int i = 0; i < v.ar_wait; i++) begin
            @(negedge clock);
            chk($sformatf("v%0d.ar_hold%0d", k, i),
                {axi.axi_arvalid, axi.axi_rready, axi.axi_araddr[29:0]}, {1'b1, 1'b0, v.araddr[29:0]});
        end
        axi.axi_arready = 1'b1;
        @(negedge clock);                       // MISS_R
        axi.axi_arready = 1'b0;
        chk($sformatf("v%0d.r_state", k), {30'd0, axi.axi_arvalid, axi.axi_rready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            axi.axi_rvalid = 1'b1;
            axi.axi_rdata  = v.beats[i];
            axi.axi_rresp  = (i == v.err_beat) ? 2'b10 : 2'b00;
            axi.axi_rlast  = (i == 3);
            fencei_i       = (i == v.fence_at);
            @(negedge clock);
            fencei_i       = 1'b0;
            axi.axi_rvalid = 1'b0;
            axi.axi_rlast  = 1'b0;
            axi.axi_rresp  = 2'b00;
            if (i < 3) chk($sformatf("v%0d.beat%0d_pready", k, i), 32'(ifu.in_pready), 32'd0);
        end
        chk($sformatf("v%0d.resp_pready", k), 32'(ifu.in_pready), 32'd1);
        chk($sformatf("v%0d.resp_data", k), ifu.in_prdata, v.exp);
        ifu.in_psel = 1'b0;
        @(negedge clock);
        chk($sformatf("v%0d.after_pready", k), 32'(ifu.in_pready), 32'd0);
    endtask

    initial begin
        localparam logic [127:0] L0 = 128'h00000044_00000033_00000022_00000011;
        localparam logic [127:0] LA = 128'h000000A4_000000A3_000000A2_000000A1;
        localparam logic [127:0] L1 = 128'h00000088_00000077_00000066_00000055;
        vt[0]  = mk(32'h8000_0008, 1, 32'h8000_0000, 0, L0,  -1, -1, 0, 32'h33);
        vt[1]  = mk(32'h8000_000C, 0, 32'h0,         0, '0,  -1, -1, 0, 32'h44);
        vt[2]  = mk(32'h8000_0100, 1, 32'h8000_0100, 5, LA,  -1, -1, 0, 32'hA1);
        vt[3]  = mk(32'h8000_0000, 1, 32'h8000_0000, 0, L0,  -1, -1, 0, 32'h11);
        vt[4]  = mk(32'h8000_0004, 0, 32'h0,         0, '0,  -1, -1, 0, 32'h22);
        vt[5]  = mk(32'h8000_0008, 1, 32'h8000_0000, 0, L0,  -1, -1, 1, 32'h33);
        vt[6]  = mk(32'h8000_0014, 1, 32'h8000_0010, 0, L1,   2, -1, 0, 32'h66);
        vt[7]  = mk(32'h8000_0018, 1, 32'h8000_0010, 0, L1,  -1, -1, 0, 32'h77);
        vt[8]  = mk(32'h8000_001C, 0, 32'h0,         0, '0,  -1,  8, 0, 32'h88);
        vt[9]  = mk(32'h8000_001C, 1, 32'h8000_0010, 0, L1,  -1,  1, 0, 32'h88);
        vt[10] = mk(32'h8000_0010, 1, 32'h8000_0010, 0, L1,  -1, -1, 0, 32'h55);
        vt[11] = mk(32'h8000_0010, 0, 32'h0,         0, '0,  -1, -1, 0, 32'h55);
        vt[12] = mk(32'h8000_0010, 1, 32'h8000_0010, 0, L1,  -1,  3, 1, 32'h55);
        vt[13] = mk(32'h8000_0018, 1, 32'h8000_0010, 0, L1,  -1, -1, 0, 32'h77);
        vt[14] = mk(32'h8000_0014, 0, 32'h0,         0, '0,  -1, -1, 0, 32'h66);

        reset = 1'b1; fencei_i = 1'b0;
        ifu.in_psel = 1'b0; ifu.in_paddr = '0;
        axi.axi_arready = 1'b0; axi.axi_rdata = '0; axi.axi_rresp = 2'b00;
        axi.axi_rlast = 1'b0; axi.axi_rvalid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("reset.outputs", {29'd0, ifu.in_pready, axi.axi_arvalid, axi.axi_rready}, 32'd0);
        chk("reset.prdata", ifu.in_prdata, 32'd0);

        for (int k = 0; k < 15; k++) run(k, vt[k]);

        // reset in the middle of a refill: bus goes quiet, previously valid lines are gone
        ifu.in_psel = 1'b1; ifu.in_paddr = 32'h8000_0020;
        @(negedge clock);                       // LOOKUP
        @(negedge clock);                       // MISS_AR
        axi.axi_arready = 1'b1;
        @(negedge clock);                       // MISS_R
        axi.axi_arready = 1'b0;
        axi.axi_rvalid = 1'b1; axi.axi_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        axi.axi_rvalid = 1'b0;
        reset = 1'b1; ifu.in_psel = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_mid.outputs", {29'd0, ifu.in_pready, axi.axi_arvalid, axi.axi_rready}, 32'd0);
        @(negedge clock);
        chk("rst_mid.idle", {29'd0, ifu.in_pready, axi.axi_arvalid, axi.axi_rready}, 32'd0);
        run(15, mk(32'h8000_0014, 1, 32'h8000_0010, 0, L1, -1, -1, 0, 32'h66));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
